modulo_muldiv_seq: RTL and testbench

Multi-cycle sequencer for the processor's multiply and divide operations. It runs one partial step per clock: shift-add for MUL, restoring division for DIV. This replaces the single-cycle combinational `*` and `/` paths of the ALU. The control unit issues a MUL/DIV with a start pulse, stalls on `busy`, and captures the result when `done` pulses. The operation encoding matches the ALU control codes (MUL = 4'b1000, DIV = 4'b1001).

---
 rtl/modulo_muldiv_seq_if.sv | 34 +++
 rtl/modulo_muldiv_seq.sv | 169 ++++++++++++++++
 tb/tb_modulo_muldiv_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/modulo_muldiv_seq_if.sv
// Request/result bundle between the control unit (master) and the mul/div sequencer (slave).
// output_resto exists only when MULDIV_REMAINDER_EN is defined.
interface modulo_muldiv_seq_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [3:0]            control_alu;
   logic [DATA_WIDTH-1:0] input_1;
   logic [DATA_WIDTH-1:0] input_2;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] output_resultado;
   logic                  zero;
   logic                  div_by_zero;
`ifdef MULDIV_REMAINDER_EN
   logic [DATA_WIDTH-1:0] output_resto;
`endif

   modport master (
      output start, control_alu, input_1, input_2,
      input  busy, done, output_resultado, zero, div_by_zero
`ifdef MULDIV_REMAINDER_EN
      , input output_resto
`endif
   );

   modport slave (
      input  start, control_alu, input_1, input_2,
      output busy, done, output_resultado, zero, div_by_zero
`ifdef MULDIV_REMAINDER_EN
      , output output_resto
`endif
   );
endinterface

// File: rtl/modulo_muldiv_seq.sv
// One-bit-per-cycle shift-add multiplier / restoring divider for the ALU MUL/DIV codes.
// Optional remainder output enabled by defining MULDIV_REMAINDER_EN.
module modulo_muldiv_seq #(
   parameter int DATA_WIDTH = 32
) (
   input logic                 clock,
   input logic                 reset_n,
   modulo_muldiv_seq_if.slave  bus
);
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1001;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  opDiv_q, opDiv_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  zero_q, zero_d;
   logic                  dbz_q, dbz_d;
`ifdef MULDIV_REMAINDER_EN
   logic [DATA_WIDTH-1:0] resto_q, resto_d;
`endif

   logic                  opValid, isDiv, accept, divZero, lastStep;
   logic [DATA_WIDTH-1:0] accNext, remNext, quoNext, stepResult;
   logic [DATA_WIDTH:0]   remShift, trialDiff;

   assign isDiv    = (bus.control_alu == OP_DIV);
   assign opValid  = (bus.control_alu == OP_MUL) || isDiv;
   assign accept   = bus.start && opValid && (state_q != CALC);
   assign divZero  = isDiv && (bus.input_2 == '0);
   assign lastStep = (state_q == CALC) && (count_q == CW'(DATA_WIDTH - 1));

   // Single iteration of each algorithm; the divider compare needs one extra bit.
   assign accNext    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign remShift   = {rem_q, quo_q[DATA_WIDTH-1]};
   assign trialDiff  = remShift - {1'b0, divisor_q};
   assign remNext    = trialDiff[DATA_WIDTH] ? remShift[DATA_WIDTH-1:0] : trialDiff[DATA_WIDTH-1:0];
   assign quoNext    = {quo_q[DATA_WIDTH-2:0], ~trialDiff[DATA_WIDTH]};
   assign stepResult = opDiv_q ? quoNext : accNext;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = divZero ? DONE : CALC;
         CALC:    if (lastStep) state_d = DONE;
         DONE:    state_d = accept ? (divZero ? DONE : CALC) : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q == CALC);
      bus.done = (state_q == DONE);
   end

   always_comb begin
      count_d   = count_q;
      opDiv_d   = opDiv_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      result_d  = result_q;
      zero_d    = zero_q;
      dbz_d     = dbz_q;
`ifdef MULDIV_REMAINDER_EN
      resto_d   = resto_q;
`endif
      if (accept) begin
         count_d   = '0;
         opDiv_d   = isDiv;
         mcand_d   = bus.input_1;
         mplier_d  = bus.input_2;
         acc_d     = '0;
         rem_d     = '0;
         quo_d     = bus.input_1;
         divisor_d = bus.input_2;
         // Divide by zero never iterates, so its outputs are published at the accept edge.
         if (divZero) begin
            result_d = '1;
            zero_d   = 1'b0;
            dbz_d    = 1'b1;
`ifdef MULDIV_REMAINDER_EN
            resto_d  = bus.input_1;
`endif
         end
      end else if (state_q == CALC) begin
         count_d = count_q + CW'(1);
         if (opDiv_q) begin
            rem_d = remNext;
            quo_d = quoNext;
         end else begin
            acc_d    = accNext;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
         end
         if (lastStep) begin
            count_d  = '0;
            result_d = stepResult;
            zero_d   = (stepResult == '0);
            dbz_d    = 1'b0;
`ifdef MULDIV_REMAINDER_EN
            resto_d  = opDiv_q ? remNext : '0;
`endif
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         opDiv_q   <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         dbz_q     <= 1'b0;
`ifdef MULDIV_REMAINDER_EN
         resto_q   <= '0;
`endif
      end else begin
         count_q   <= count_d;
         opDiv_q   <= opDiv_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         dbz_q     <= dbz_d;
`ifdef MULDIV_REMAINDER_EN
         resto_q   <= resto_d;
`endif
      end
   end

   assign bus.output_resultado = result_q;
   assign bus.zero             = zero_q;
   assign bus.div_by_zero      = dbz_q;
`ifdef MULDIV_REMAINDER_EN
   assign bus.output_resto     = resto_q;
`endif

endmodule

// File: tb/tb_modulo_muldiv_seq.sv
// Scoreboard bench for modulo_muldiv_seq: expected results are queued at each accepted
// start and compared, together with latency and busy length, whenever done pulses.
module tb_modulo_muldiv_seq;
   localparam int W = 32;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1001;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   // Free-running clock, 10 time units per period
   always #5 clock = ~clock;

   modulo_muldiv_seq_if #(.DATA_WIDTH(W)) bus();

   modulo_muldiv_seq #(.DATA_WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      logic         dbz;
      logic [W-1:0] resto;
      int           lat;
      int           busyN;
      int           acceptCycle;
   } exp_t;

   exp_t sbQueue[$];
   exp_t monEntry;
   int   testsRun = 0;
   int   testsFailed = 0;
   int   cycleCnt = 0;
   int   busyCnt = 0;

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Counts rising edges so latency can be measured from the accept edge
   always @(posedge clock) cycleCnt++;

   // Monitor: measures busy length and retires one scoreboard entry per done pulse
   always @(negedge clock) begin
      if (bus.busy) busyCnt++;
      if (bus.done) begin
         if (sbQueue.size() == 0) begin
            checkOutput("unexpected_done", 64'd1, 64'd0);
         end else begin
            monEntry = sbQueue.pop_front();
            checkOutput("result", 64'(bus.output_resultado), 64'(monEntry.res));
            checkOutput("zero", 64'(bus.zero), 64'(monEntry.zero));
            checkOutput("div_by_zero", 64'(bus.div_by_zero), 64'(monEntry.dbz));
`ifdef MULDIV_REMAINDER_EN
            checkOutput("resto", 64'(bus.output_resto), 64'(monEntry.resto));
`endif
            checkOutput("latency", 64'(cycleCnt - monEntry.acceptCycle), 64'(monEntry.lat));
            checkOutput("busy_cycles", 64'(busyCnt), 64'(monEntry.busyN));
         end
         busyCnt = 0;
      end
   end

   // Drives one start pulse; operands are scrambled right after the edge to prove latching
   task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      exp_t e;
      @(negedge clock);
      bus.start       = 1'b1;
      bus.control_alu = op;
      bus.input_1     = a;
      bus.input_2     = b;
      @(posedge clock);
      #1;
      bus.start   = 1'b0;
      bus.input_1 = $urandom;
      bus.input_2 = $urandom;
      if (push) begin
         e.acceptCycle = cycleCnt;
         e.dbz   = 1'b0;
         e.lat   = W;
         e.busyN = W;
         if (op == OP_MUL) begin
            e.res   = a * b;
            e.resto = '0;
         end else if (b == '0) begin
            e.res   = '1;
            e.dbz   = 1'b1;
            e.resto = a;
            e.lat   = 0;
            e.busyN = 0;
         end else begin
            e.res   = a / b;
            e.resto = a % b;
         end
         e.zero = (e.res == '0);
         sbQueue.push_back(e);
      end
   endtask

   // Waits until every queued result has been delivered, bounded by a cycle budget
   task automatic waitIdle(input int maxCycles);
      int n = 0;
      while ((sbQueue.size() != 0 || bus.busy) && n < maxCycles) begin
         @(negedge clock);
         n++;
      end
      if (sbQueue.size() != 0 || bus.busy) begin
         checkOutput("timeout", 64'd1, 64'd0);
         sbQueue.delete();
      end
      @(negedge clock);
   endtask

   // Advances until done is seen just after a rising edge, bounded by a cycle budget
   task automatic waitDone(input int maxCycles);
      int n = 0;
      while (n < maxCycles) begin
         @(posedge clock);
         #1;
         if (bus.done) break;
         n++;
      end
      if (!bus.done) checkOutput("done_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.control_alu = 4'b0000;
      bus.input_1     = '0;
      bus.input_2     = '0;

      repeat (2) @(negedge clock);
      checkOutput("reset_busy", 64'(bus.busy), 64'd0);
      checkOutput("reset_done", 64'(bus.done), 64'd0);
      checkOutput("reset_result", 64'(bus.output_resultado), 64'd0);
      checkOutput("reset_zero", 64'(bus.zero), 64'd0);
      checkOutput("reset_dbz", 64'(bus.div_by_zero), 64'd0);
      reset_n = 1'b1;

      applyStimulus(OP_MUL, 32'd7, 32'd6, 1'b1);
      waitIdle(100);
      applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1);
      waitIdle(100);
      applyStimulus(OP_MUL, 32'd0, 32'd5, 1'b1);
      waitIdle(100);
      applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b1);
      waitIdle(100);
      applyStimulus(OP_DIV, 32'd55, 32'd0, 1'b1);
      waitIdle(100);

      // Start during CALC must be dropped without disturbing the running MUL
      applyStimulus(OP_MUL, 32'd7, 32'd6, 1'b1);
      repeat (9) @(negedge clock);
      applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
      checkOutput("calc_ignore_busy", 64'(bus.busy), 64'd1);

      // Back-to-back: issue a DIV in the DONE cycle of that MUL
      waitDone(100);
      applyStimulus(OP_DIV, 32'd20, 32'd4, 1'b1);
      checkOutput("b2b_busy", 64'(bus.busy), 64'd1);
      checkOutput("b2b_done", 64'(bus.done), 64'd0);
      checkOutput("b2b_prev_result", 64'(bus.output_resultado), 64'd42);
      waitIdle(100);

      applyStimulus(4'b0010, 32'd3, 32'd4, 1'b0);
      checkOutput("invalid_busy", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clock);
      checkOutput("invalid_busy_later", 64'(bus.busy), 64'd0);
      checkOutput("invalid_result_held", 64'(bus.output_resultado), 64'd5);

      for (int i = 0; i < 4; i++) begin
         applyStimulus((i % 2) ? OP_DIV : OP_MUL, W'($urandom), W'($urandom_range(1, 5000)), 1'b1);
         waitIdle(100);
      end

      // Reset mid-CALC aborts the DIV and clears outputs immediately
      applyStimulus(OP_DIV, 32'd1000, 32'd3, 1'b1);
      repeat (14) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(bus.busy), 64'd0);
      checkOutput("abort_done", 64'(bus.done), 64'd0);
      checkOutput("abort_result", 64'(bus.output_resultado), 64'd0);
      checkOutput("abort_zero", 64'(bus.zero), 64'd0);
      checkOutput("abort_dbz", 64'(bus.div_by_zero), 64'd0);
`ifdef MULDIV_REMAINDER_EN
      checkOutput("abort_resto", 64'(bus.output_resto), 64'd0);
`endif
      sbQueue.delete();
      busyCnt = 0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (40) @(negedge clock);
      applyStimulus(OP_DIV, 32'd9, 32'd3, 1'b1);
      waitIdle(100);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
